// File: rtl/gain_stage.sv
// Two-stage per-channel gain block: stage 1 computes the full-precision scaled
// sample from the channel's gain/mode, stage 2 clamps to W bits and flags saturation.

module gain_cfg_lane #(
  parameter int GW   = 8,
  parameter int FRAC = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [GW-1:0] gain_i,
  input  logic          mode_i,
  output logic [GW-1:0] gain_o,
  output logic          mode_o
);
  localparam logic [GW-1:0] UNITY = GW'(1) << FRAC;

  logic [GW-1:0] gain_q, gain_d;
  logic          mode_q, mode_d;

  always_comb begin
    gain_d = gain_q;
    mode_d = mode_q;
    if (we) begin
      gain_d = gain_i;
      mode_d = mode_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gain_q <= UNITY;
      mode_q <= 1'b1;
    end else begin
      gain_q <= gain_d;
      mode_q <= mode_d;
    end
  end

  assign gain_o = gain_q;
  assign mode_o = mode_q;
endmodule

module gain_stage #(
  parameter int W    = 16,
  parameter int NCH  = 4,
  parameter int GW   = 8,
  parameter int FRAC = 4,
  localparam int CW  = $clog2(NCH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  data_i,
  input  logic [CW-1:0] ch_i,
  input  logic          valid_i,
  output logic          ready_o,
  output logic [W-1:0]  data_o,
  output logic [CW-1:0] ch_o,
  output logic          sat_o,
  output logic          valid_o,
  input  logic          ready_i,
  input  logic          cfg_we,
  input  logic [CW-1:0] cfg_ch,
  input  logic [GW-1:0] cfg_gain,
  input  logic          cfg_mode,
  output logic [15:0]   sat_cnt,
  input  logic          sat_clr
);
  localparam int RW = W + GW + 1;
  // Smallest magnitudes just outside the W-bit range; enough to force the clamp.
  localparam logic [RW-1:0] POS_OVF = {{(RW-W){1'b0}}, 1'b1, {(W-1){1'b0}}};
  localparam logic [RW-1:0] NEG_OVF = ~POS_OVF;
  localparam logic [W-1:0]  MAXV    = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]  MINV    = {1'b1, {(W-1){1'b0}}};

  logic [NCH-1:0][GW-1:0] gain;
  logic [NCH-1:0]         mode;

  for (genvar i = 0; i < NCH; i++) begin : g_lane
    gain_cfg_lane #(.GW(GW), .FRAC(FRAC)) u_lane (
      .clk    (clk),
      .rst    (rst),
      .we     (cfg_we && (cfg_ch == CW'(i))),
      .gain_i (cfg_gain),
      .mode_i (cfg_mode),
      .gain_o (gain[i]),
      .mode_o (mode[i])
    );
  end

  logic [2:1]     vld_pipe_q, vld_pipe_d;
  logic [CW-1:0]  ch1_q, ch1_d, ch2_q, ch2_d;
  logic [RW-1:0]  r_q, r_d;
  logic [W-1:0]   data_q, data_d;
  logic           sat_q, sat_d;
  logic [15:0]    sat_cnt_q, sat_cnt_d;

  logic                 en;
  logic [GW-1:0]        sel_gain;
  logic                 sel_mode;
  logic signed [RW-1:0] a_ext, g_ext, prod;
  logic [2*W-1:0]       shl_wide;
  logic                 big_gain, shl_fits, r_fits;
  logic [RW-1:0]        r_calc;
  logic [W-1:0]         clamp_val;

  assign en       = ~vld_pipe_q[2] | ready_i;
  assign sel_gain = gain[ch_i];
  assign sel_mode = mode[ch_i];

  always_comb begin
    a_ext    = {{(RW-W){data_i[W-1]}}, data_i};
    g_ext    = {{(RW-GW){1'b0}}, sel_gain};
    prod     = a_ext * g_ext;
    // 2W bits hold any in-range shift (gain < W) exactly.
    shl_wide = {{W{data_i[W-1]}}, data_i} << sel_gain;
    big_gain = {{(32-GW){1'b0}}, sel_gain} >= 32'(W);
    shl_fits = (&shl_wide[2*W-1:W-1]) | ~(|shl_wide[2*W-1:W-1]);
    if (sel_mode)
      r_calc = prod >>> FRAC;
    else if ((data_i != '0) && (big_gain || !shl_fits))
      r_calc = data_i[W-1] ? NEG_OVF : POS_OVF;
    else
      r_calc = {{(RW-W){shl_wide[W-1]}}, shl_wide[W-1:0]};
  end

  always_comb begin
    r_fits    = (&r_q[RW-1:W-1]) | ~(|r_q[RW-1:W-1]);
    clamp_val = r_fits ? r_q[W-1:0] : (r_q[RW-1] ? MINV : MAXV);
  end

  always_comb begin
    vld_pipe_d = vld_pipe_q;
    ch1_d      = ch1_q;
    r_d        = r_q;
    ch2_d      = ch2_q;
    data_d     = data_q;
    sat_d      = sat_q;
    sat_cnt_d  = sat_cnt_q;
    if (en) begin
      vld_pipe_d = {vld_pipe_q[1], valid_i};
      ch1_d      = ch_i;
      r_d        = r_calc;
      ch2_d      = ch1_q;
      data_d     = clamp_val;
      sat_d      = ~r_fits;
    end
    if (sat_clr)
      sat_cnt_d = '0;
    else if (en && vld_pipe_q[1] && !r_fits && !(&sat_cnt_q))
      sat_cnt_d = sat_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe_q <= '0;
      ch1_q      <= '0;
      r_q        <= '0;
      ch2_q      <= '0;
      data_q     <= '0;
      sat_q      <= 1'b0;
      sat_cnt_q  <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      ch1_q      <= ch1_d;
      r_q        <= r_d;
      ch2_q      <= ch2_d;
      data_q     <= data_d;
      sat_q      <= sat_d;
      sat_cnt_q  <= sat_cnt_d;
    end
  end

  assign ready_o = en;
  assign valid_o = vld_pipe_q[2];
  assign data_o  = data_q;
  assign ch_o    = ch2_q;
  assign sat_o   = sat_q;
  assign sat_cnt = sat_cnt_q;
endmodule

// File: tb/tb_gain_stage.sv
// Scoreboard bench for gain_stage: directed samples push expected outputs,
// a negedge monitor pops and compares on every output transfer.

module tb_gain_stage;
  localparam int W = 16, NCH = 4, CW = 2, GW = 8, FRAC = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [W-1:0]  data_i = '0;
  logic [CW-1:0] ch_i = '0;
  logic          valid_i = 1'b0;
  logic          ready_o;
  logic [W-1:0]  data_o;
  logic [CW-1:0] ch_o;
  logic          sat_o;
  logic          valid_o;
  logic          ready_i = 1'b1;
  logic          cfg_we = 1'b0;
  logic [CW-1:0] cfg_ch = '0;
  logic [GW-1:0] cfg_gain = '0;
  logic          cfg_mode = 1'b0;
  logic [15:0]   sat_cnt;
  logic          sat_clr = 1'b0;

  gain_stage #(.W(W), .NCH(NCH), .GW(GW), .FRAC(FRAC)) dut (
    .clk(clk), .rst(rst), .data_i(data_i), .ch_i(ch_i), .valid_i(valid_i),
    .ready_o(ready_o), .data_o(data_o), .ch_o(ch_o), .sat_o(sat_o),
    .valid_o(valid_o), .ready_i(ready_i), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_gain(cfg_gain), .cfg_mode(cfg_mode), .sat_cnt(sat_cnt), .sat_clr(sat_clr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0]  d;
    logic [CW-1:0] ch;
    logic          sat;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  bit   rand_rdy = 1'b0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endfunction

  always @(posedge clk) begin
    #1;
    if (rand_rdy) ready_i = 1'($urandom_range(0, 1));
  end

  logic          prev_stall = 1'b0;
  logic [W-1:0]  prev_d;
  logic [CW-1:0] prev_ch;
  exp_t          e;
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      chk("ready_o", 32'(ready_o), 32'(!(valid_o && !ready_i)));
      if (prev_stall && valid_o) begin
        chk("stall_data", 32'(data_o), 32'(prev_d));
        chk("stall_ch", 32'(ch_o), 32'(prev_ch));
      end
      if (valid_o && ready_i) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_out: got data %0h ch %0d, expected no output", data_o, ch_o);
        end else begin
          e = sb.pop_front();
          chk("out{sat,ch,data}", 32'({sat_o, ch_o, data_o}), 32'({e.sat, e.ch, e.d}));
        end
      end
      prev_stall = valid_o && !ready_i;
      prev_d     = data_o;
      prev_ch    = ch_o;
    end
  end

  task automatic send(input logic [W-1:0] d, input logic [CW-1:0] c,
                      input logic [W-1:0] ed, input logic es);
    int t;
    sb.push_back('{d: ed, ch: c, sat: es});
    data_i  = d;
    ch_i    = c;
    valid_i = 1'b1;
    t = 0;
    @(negedge clk);
    while (!ready_o && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!ready_o) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: ready_o stayed 0, expected 1 within 100 cycles");
    end
    @(posedge clk);
    #1;
    valid_i = 1'b0;
  endtask

  task automatic cfg(input logic [CW-1:0] c, input logic [GW-1:0] g, input logic m);
    cfg_we = 1'b1; cfg_ch = c; cfg_gain = g; cfg_mode = m;
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((sb.size() != 0 || valid_o) && t < 60) begin
      @(posedge clk);
      t++;
    end
    if (t >= 60) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: %0d outputs still pending, expected 0", sb.size());
    end
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  logic [W-1:0] st_d [8] = '{16'd100, 16'd200, 16'hFFF9, 16'd300,
                             16'hFE70, 16'h0900, 16'd600, 16'd1};
  logic [CW-1:0] st_c [8] = '{2'd1, 2'd1, 2'd1, 2'd0, 2'd1, 2'd0, 2'd1, 2'd3};
  logic [W-1:0] st_e [8] = '{16'd250, 16'd500, 16'hFFEE, 16'd4800,
                             16'hFC18, 16'h7FFF, 16'd1500, 16'h7FFF};
  logic         st_s [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready_o", 32'(ready_o), 32'd1);
    chk("rst_valid_o", 32'(valid_o), 32'd0);
    chk("rst_data_o", 32'(data_o), 32'd0);
    chk("rst_ch_o", 32'(ch_o), 32'd0);
    chk("rst_sat_o", 32'(sat_o), 32'd0);
    chk("rst_sat_cnt", 32'(sat_cnt), 32'd0);
    rst = 1'b0;
    chk("post_rst_ready_o", 32'(ready_o), 32'd1);

    // Unity default gain and two-cycle latency
    send(16'h1234, 2'd2, 16'h1234, 1'b0);
    chk("lat_cycle1_valid", 32'(valid_o), 32'd0);
    @(posedge clk);
    #1;
    chk("lat_cycle2_valid", 32'(valid_o), 32'd1);
    drain();

    cfg(2'd1, 8'h28, 1'b1);
    send(16'd1000, 2'd1, 16'd2500, 1'b0);
    send(16'hFC18, 2'd1, 16'hF63C, 1'b0);
    drain();

    cfg(2'd0, 8'd4, 1'b0);
    send(16'h0100, 2'd0, 16'h1000, 1'b0);
    send(16'h0900, 2'd0, 16'h7FFF, 1'b1);
    drain();
    chk("sat_cnt_1", 32'(sat_cnt), 32'd1);
    send(16'hF700, 2'd0, 16'h8000, 1'b1);
    drain();
    chk("sat_cnt_2", 32'(sat_cnt), 32'd2);

    cfg(2'd3, 8'd20, 1'b0);
    send(16'h0000, 2'd3, 16'h0000, 1'b0);
    send(16'h0001, 2'd3, 16'h7FFF, 1'b1);
    send(16'hFFFF, 2'd3, 16'h8000, 1'b1);
    drain();
    chk("sat_cnt_4", 32'(sat_cnt), 32'd4);

    // Config write on the same edge as a sample: the sample sees the old unity gain
    cfg_we = 1'b1; cfg_ch = 2'd2; cfg_gain = 8'd15; cfg_mode = 1'b0;
    send(16'h0100, 2'd2, 16'h0100, 1'b0);
    cfg_we = 1'b0;
    send(16'h0001, 2'd2, 16'h7FFF, 1'b1);
    send(16'hFFFF, 2'd2, 16'h8000, 1'b0);
    send(16'h0003, 2'd2, 16'h7FFF, 1'b1);
    drain();
    chk("sat_cnt_6", 32'(sat_cnt), 32'd6);

    sat_clr = 1'b1;
    @(posedge clk);
    #1;
    sat_clr = 1'b0;
    chk("sat_clr", 32'(sat_cnt), 32'd0);

    // Back-pressure stream
    rand_rdy = 1'b1;
    for (int i = 0; i < 8; i++) send(st_d[i], st_c[i], st_e[i], st_s[i]);
    rand_rdy = 1'b0;
    @(posedge clk);
    #2;
    ready_i = 1'b1;
    drain();
    chk("stream_sat_cnt", 32'(sat_cnt), 32'd2);

    // Counter sticks at all-ones
    force dut.sat_cnt_q = 16'hFFFE;
    @(posedge clk);
    #1;
    release dut.sat_cnt_q;
    for (int i = 0; i < 3; i++) send(16'h0001, 2'd3, 16'h7FFF, 1'b1);
    drain();
    chk("sat_cnt_stick", 32'(sat_cnt), 32'hFFFF);

    // Clear wins over a simultaneous increment
    send(16'h0001, 2'd3, 16'h7FFF, 1'b1);
    sat_clr = 1'b1;
    @(posedge clk);
    #1;
    sat_clr = 1'b0;
    chk("sat_clr_priority", 32'(sat_cnt), 32'd0);
    drain();
    chk("sat_clr_after_drain", 32'(sat_cnt), 32'd0);

    // Reset mid-stream
    send(16'h0100, 2'd1, 16'h0280, 1'b0);
    @(posedge clk);
    #1;
    chk("pre_rst_valid", 32'(valid_o), 32'd1);
    rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(valid_o), 32'd0);
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("post_rst2_ready", 32'(ready_o), 32'd1);
    send(16'd1000, 2'd1, 16'd1000, 1'b0);
    send(16'h0001, 2'd3, 16'h0001, 1'b0);
    send(16'h0100, 2'd0, 16'h0100, 1'b0);
    drain();
    chk("post_rst2_sat_cnt", 32'(sat_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
